// File: rtl/suite_pkg.sv
// Shared types and constants for the 240p suite pattern-memory path.
package suite_pkg;

  localparam int VRAM_AW       = 17;
  localparam int VRAM_DW       = 8;
  localparam int VRAM_WR_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RDW  = 2'd2,
    WR   = 2'd3
  } vram_arb_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle for the VRAM arbiter: pixel timing, scanout fetch, ioctl
// download and the single-port RAM side. The arbiter is the slave; the
// surrounding video core / HPS bridge / RAM wrapper form the master side.
interface vram_arbiter_if
  import suite_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
);

  logic          ce_pix;
  logic          active;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [DW-1:0] ioctl_data;
  logic          ioctl_wait;
  logic          ovf;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  ce_pix, active, fetch_req, fetch_addr,
    input  ioctl_wr, ioctl_addr, ioctl_data, ram_rdata,
    output fetch_data, fetch_valid, ioctl_wait, ovf,
    output ram_addr, ram_wdata, ram_we
  );

  modport master (
    output ce_pix, active, fetch_req, fetch_addr,
    output ioctl_wr, ioctl_addr, ioctl_data, ram_rdata,
    input  fetch_data, fetch_valid, ioctl_wait, ovf,
    input  ram_addr, ram_wdata, ram_we
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO of pending download writes ({addr,data} entries).
// Push is ignored when full and pop is ignored when empty; a simultaneous
// push and pop leaves the count unchanged.
module vram_wr_fifo
  import suite_pkg::*;
#(
  parameter int AW    = VRAM_AW,
  parameter int DW    = VRAM_DW,
  parameter int DEPTH = VRAM_WR_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign {head_addr, head_data} = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  // Entry storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_addr, push_data};
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads always win, download writes are
// queued in vram_wr_fifo and drained into idle clocks between pixel fetches.
// Optional build macro VRAM_ARB_BLANK_ONLY_EN: when defined, queued writes
// are only issued while active=0 (tear-free download); otherwise active is
// ignored.
module vram_arbiter
  import suite_pkg::*;
#(
  parameter int AW    = VRAM_AW,
  parameter int DW    = VRAM_DW,
  parameter int DEPTH = VRAM_WR_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  vram_arb_state_t state;
  logic [AW-1:0]   head_addr;
  logic [DW-1:0]   head_data;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            wr_ok;
  logic            go_rd;
  logic            go_wr;

  vram_wr_fifo #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.ioctl_wr),
    .push_addr (bus.ioctl_addr),
    .push_data (bus.ioctl_data),
    .pop       (go_wr),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

`ifdef VRAM_ARB_BLANK_ONLY_EN
  assign wr_ok = ~empty & ~bus.active;
`else
  logic unused_active;
  assign unused_active = bus.active;
  assign wr_ok = ~empty;
`endif

  // RD always proceeds to RDW, so requests arriving in RD are not considered.
  assign go_rd = bus.ce_pix & bus.fetch_req & (state != RD);
  assign go_wr = ~go_rd & wr_ok & (state != RD);

  assign bus.ioctl_wait = (count >= CW'(DEPTH - 1));

  // Arbitration FSM with registered RAM controls and read-return register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus.ram_addr    <= '0;
      bus.ram_wdata   <= '0;
      bus.ram_we      <= 1'b0;
      bus.fetch_data  <= '0;
      bus.fetch_valid <= 1'b0;
    end else begin
      bus.ram_we      <= 1'b0;
      bus.fetch_valid <= 1'b0;
      case (state)
        RD: state <= RDW;
        default: begin
          if (state == RDW) begin
            bus.fetch_data  <= bus.ram_rdata;
            bus.fetch_valid <= 1'b1;
          end
          if (go_rd) begin
            state        <= RD;
            bus.ram_addr <= bus.fetch_addr;
          end else if (go_wr) begin
            state         <= WR;
            bus.ram_addr  <= head_addr;
            bus.ram_wdata <= head_data;
            bus.ram_we    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Sticky overflow: a download write arrived while the FIFO was full.
  always_ff @(posedge clk) begin
    if (reset)                     bus.ovf <= 1'b0;
    else if (bus.ioctl_wr & full)  bus.ovf <= 1'b1;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM arbiter for the 240p suite's pattern memory. It shares one synchronous RAM between two users: the video scanout path, which fetches one byte per `ce_pix`, and the HPS `ioctl` download path, which loads new pattern bytes. Scanout reads always win. Download writes are buffered in a small FIFO and fill the idle clocks between pixel fetches, with backpressure through `ioctl_wait`.

## Interface
Parameters:
- `AW`, 17, VRAM address width.
- `DW`, 8, VRAM data width.
- `DEPTH`, 4, write FIFO depth; power of two, minimum 2.

Ports:
- `clk` in 1: system clock, 4× the pixel rate.
- `reset` in 1: synchronous, active-high.
- `ce_pix` in 1: pixel enable, one clk wide, period ≥ 3 clks (4 nominal).
- `active` in 1: video display-enable; used only under the macro.
- `fetch_req` in 1: scanout wants a byte this pixel; sampled only when `ce_pix`=1.
- `fetch_addr` in AW: address for the scanout read.
- `fetch_data` out DW: byte returned by the read.
- `fetch_valid` out 1: one-clk pulse; `fetch_data` is valid while it is high.
- `ioctl_wr` in 1: download write strobe.
- `ioctl_addr` in AW: download write address.
- `ioctl_data` in DW: download write data.
- `ioctl_wait` out 1: backpressure to the HPS.
- `ovf` out 1: sticky flag; a write was dropped because the FIFO was full.
- `ram_addr` out AW: RAM address, registered.
- `ram_wdata` out DW: RAM write data, registered.
- `ram_we` out 1: RAM write enable, registered.
- `ram_rdata` in DW: RAM read data; 1-clk registered read latency.

## Operation
- States: IDLE, RD, RDW, WR. The state register is updated every clk.
- Next-state decision, taken from IDLE, WR or RDW, in priority order:
  - `ce_pix & fetch_req` → RD.
  - else FIFO not empty (and write permitted, see Configuration) → WR.
  - else → IDLE.
- RD:
  - drives `ram_addr`=`fetch_addr`, which is captured at the request cycle.
  - `ram_we`=0.
  - always goes to RDW.
- RDW:
  - `ram_rdata` is valid in this state.
  - `fetch_data` <= `ram_rdata`, `fetch_valid` <= 1.
- WR:
  - pops the FIFO head; `ram_addr`/`ram_wdata` = head entry, `ram_we`=1 for exactly this clk.
- The `ce_pix & fetch_req` input is ignored while in RD. If `ce_pix`=1 arrives during RD, that request is dropped and produces no `fetch_valid`. This is a protocol violation by the caller.
- FIFO rules:
  - Push on `ioctl_wr` when not full.
  - Simultaneous push and pop are both honoured; the count is unchanged.
  - `ioctl_wr` when full: the write is discarded and `ovf` is set to 1.
- `ioctl_wait` = (count ≥ DEPTH−1), combinational from the count register.
- `fetch_data` holds its last value between pulses.
- Address and data widths are passed through unchanged; there is no wrap or translation.

## Timing
- Reset values:
  - state IDLE, FIFO empty.
  - `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - `fetch_valid`=0, `fetch_data`=0.
  - `ioctl_wait`=0, `ovf`=0.
- Reset mid-operation aborts any in-flight read (no `fetch_valid`) and discards all FIFO entries.
- Read latency: request at clk T → RD at T+1 → RDW at T+2 → `fetch_valid` high at T+3. This completes before the next `ce_pix` at T+4.
- A read preempts pending writes. A WR in progress at T completes; RD still starts at T+1.
- Write throughput:
  - at least 2 writes per 4-clk pixel period during scanout reads;
  - 1 write per clk when `fetch_req`=0.
- Write latency: `ioctl_wr` at T → earliest `ram_we` at T+2.

## Configuration
- `VRAM_ARB_BLANK_ONLY_EN`:
  - Defined: WR is entered only when `active`=0. Writes wait in the FIFO during visible lines, so download is tear-free.
  - Undefined: `active` is ignored and writes interleave with scanout at any time.

## Structure
- `suite_pkg` holds:
  - the state enum `vram_arb_state_t` (IDLE, RD, RDW, WR);
  - constants `VRAM_AW`=17, `VRAM_DW`=8 and `VRAM_WR_DEPTH`=4.
- One sub-module, `vram_wr_fifo`: a synchronous FIFO with push, pop, `{addr,data}` entries, a count output, and `full` and `empty` flags.
- The arbiter FSM and read-return register live in `vram_arbiter`.

## Test plan
1. Scanout read:
   - Stimulus: RAM preloaded with 0x5A at 0x00100; `ce_pix` period 4; `fetch_req`=1 with `fetch_addr`=0x00100.
   - Required: `fetch_valid` pulses at T+3 with `fetch_data`=0x5A, and there is no `ram_we` during RD.
2. Read/write collision:
   - Stimulus: `ioctl_wr` to 0x00010 with data 0xA5 in the same clk as `ce_pix & fetch_req`.
   - Required: RD occurs at T+1; `ram_we` with addr 0x00010 and data 0xA5 occurs at T+3; readback gives 0xA5.
3. Backpressure:
   - Stimulus: 4 back-to-back `ioctl_wr` during continuous reads.
   - Required: `ioctl_wait` rises when count reaches 3; no write is lost; `ovf` stays 0.
4. Overflow:
   - Stimulus: 5 `ioctl_wr` on consecutive clks while forcing continuous RD.
   - Required: the 5th write is dropped and `ovf` becomes 1 and stays 1 until reset.
5. Reset mid-operation:
   - Stimulus: assert `reset` during RDW with 2 entries queued.
   - Required: no `fetch_valid`; FIFO empty; every output returns to its reset value in the next clk.
6. `VRAM_ARB_BLANK_ONLY_EN` defined:
   - Stimulus: queued writes while `active`=1.
   - Required: no `ram_we` until `active`=0; then all writes drain in order.
